key_buffer_ctrl: RTL and testbench
==================================

KEY_BUFFER_CTRL -- requirements
Module: key_buffer_ctrl

Interface
REQ-001 Parameter SIZE, default 10, depth of the controlled keypoint buffer (2..1023).
REQ-002 i_clk  input  1  single clock, all logic on rising edge.
REQ-003 i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_frame_start  input  1  one-cycle pulse, new frame begins.
REQ-005 i_frame_end  input  1  one-cycle pulse, last candidate of frame delivered.
REQ-006 i_kp_valid  input  1  candidate keypoint present from extractor this cycle.
REQ-007 o_buf_valid  output  1  drives buffer insert strobe.
REQ-008 o_buf_next  output  1  drives buffer shift strobe (pops tail entry).
REQ-009 o_drain_valid  output  1  buffer tail entry offered downstream.
REQ-010 i_drain_ready  input  1  downstream accepts tail entry.
REQ-011 o_drain_last  output  1  offered entry is final of frame.
REQ-012 o_frame_done  output  1  one-cycle pulse, drain complete.
REQ-013 o_busy  output  1  high in any state except IDLE.
REQ-014 o_kp_count  output  10  candidates accepted this frame, saturating at SIZE.

Function
REQ-015 States IDLE, FLUSH, FILL, DRAIN; encoding 2 bits.
REQ-016 IDLE: all strobes 0; i_frame_start -> FLUSH, counters cleared.
REQ-017 FLUSH: o_buf_next=1, o_buf_valid=0 for exactly SIZE cycles (zero-fills buffer), then -> FILL.
REQ-018 FILL: o_buf_valid = i_kp_valid, o_buf_next=0; each accepted candidate increments o_kp_count, saturating at SIZE.
REQ-019 FILL + i_frame_end: candidate on same cycle accepted; next state DRAIN with remaining = o_kp_count after that update.
REQ-020 FILL + i_frame_end with count 0: -> IDLE, o_frame_done pulsed next cycle, no drain beats.
REQ-021 DRAIN: o_drain_valid=1 while remaining>0; o_drain_last = (remaining==1).
REQ-022 DRAIN handshake: o_drain_valid & i_drain_ready -> o_buf_next=1 same cycle (combinational), remaining decrements; next tail valid the following cycle, no bubble.
REQ-023 o_drain_valid SHALL NOT drop without handshake; stalls hold all outputs.
REQ-024 Final handshake -> IDLE; o_frame_done=1 for the one cycle after.
REQ-025 i_kp_valid outside FILL ignored (o_buf_valid=0).
REQ-026 i_frame_start in FLUSH/FILL/DRAIN aborts frame: -> FLUSH, counters cleared, no o_frame_done.
REQ-027 i_frame_start and i_frame_end same cycle: start wins.
REQ-028 i_frame_end outside FILL ignored.
REQ-029 o_buf_valid and o_buf_next never both 1.

Reset
REQ-030 Reset low at rising edge: state IDLE, counters 0, all outputs 0 next cycle, regardless of state; mid-drain beats discarded.

Configuration
REQ-031 KEY_BUFFER_CTRL_DROP_CNT_EN defined: output o_drop_count (16 b) counts i_kp_valid cycles outside FILL and FILL accepts beyond SIZE, saturating at 0xFFFF, cleared on i_frame_start; undefined: port and logic absent.

Structure
REQ-032 Shared package holds state enum kbc_state_t and count width constant KBC_CNT_W.
REQ-033 Single module; no sub-module; counter widths derived from SIZE.

Verification
REQ-034 SIZE=10, start -> o_buf_next high exactly 10 cycles, then FILL, o_busy=1 throughout.
REQ-035 4 candidates, frame_end, ready tied 1 -> 4 drain beats consecutive, last on 4th, o_frame_done next cycle.
REQ-036 15 candidates -> o_kp_count=10, 10 beats; with macro defined o_drop_count=5.
REQ-037 3 candidates, ready toggled 1010 -> beats only on ready cycles, outputs stable while stalled.
REQ-038 frame_start mid-DRAIN after 2 of 5 beats -> FLUSH, no o_frame_done, count 0.
REQ-039 Reset asserted mid-FLUSH -> IDLE, all outputs 0 next cycle; frame_end with 0 candidates -> o_frame_done, zero beats.

Source files
------------

// File: rtl/key_buffer_ctrl_pkg.sv
// Shared types and widths for the keypoint buffer controller.
package key_buffer_ctrl_pkg;

  localparam int unsigned KBC_CNT_W  = 10;
  localparam int unsigned KBC_DROP_W = 16;

  typedef enum logic [1:0] {
    KBC_IDLE  = 2'd0,
    KBC_FLUSH = 2'd1,
    KBC_FILL  = 2'd2,
    KBC_DRAIN = 2'd3
  } kbc_state_t;

endpackage

// File: rtl/key_buffer_ctrl_if.sv
// Extractor / buffer / downstream signal bundle for key_buffer_ctrl.
// Optional o_drop_count exists only when KEY_BUFFER_CTRL_DROP_CNT_EN is defined.
interface key_buffer_ctrl_if;
  import key_buffer_ctrl_pkg::*;

  logic                 i_frame_start;
  logic                 i_frame_end;
  logic                 i_kp_valid;
  logic                 i_drain_ready;
  logic                 o_buf_valid;
  logic                 o_buf_next;
  logic                 o_drain_valid;
  logic                 o_drain_last;
  logic                 o_frame_done;
  logic                 o_busy;
  logic [KBC_CNT_W-1:0] o_kp_count;
`ifdef KEY_BUFFER_CTRL_DROP_CNT_EN
  logic [KBC_DROP_W-1:0] o_drop_count;
`endif

  modport slave (
    input  i_frame_start, i_frame_end, i_kp_valid, i_drain_ready,
    output o_buf_valid, o_buf_next, o_drain_valid, o_drain_last,
           o_frame_done, o_busy, o_kp_count
`ifdef KEY_BUFFER_CTRL_DROP_CNT_EN
    , output o_drop_count
`endif
  );

  modport master (
    output i_frame_start, i_frame_end, i_kp_valid, i_drain_ready,
    input  o_buf_valid, o_buf_next, o_drain_valid, o_drain_last,
           o_frame_done, o_busy, o_kp_count
`ifdef KEY_BUFFER_CTRL_DROP_CNT_EN
    , input o_drop_count
`endif
  );

endinterface

// File: rtl/key_buffer_ctrl.sv
// Keypoint buffer controller: zero-fills the buffer, gathers one frame of
// candidates, then drains them downstream with a valid/ready handshake.
// Optional dropped-candidate counter: define KEY_BUFFER_CTRL_DROP_CNT_EN.
module key_buffer_ctrl
  import key_buffer_ctrl_pkg::*;
#(
  parameter int unsigned SIZE = 10
) (
  input logic             i_clk,
  input logic             i_rst_n,
  key_buffer_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(SIZE + 1);
  localparam int unsigned FL_W  = $clog2(SIZE);

  kbc_state_t       state_q, state_d;
  logic [FL_W-1:0]  flush_q, flush_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [CNT_W-1:0] count_inc;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             dvalid_q, dvalid_d;
  logic             dlast_q, dlast_d;
  logic             buf_valid_c, buf_next_c;

  // Next-state, counter updates and buffer strobes
  always_comb begin
    state_d     = state_q;
    flush_d     = flush_q;
    count_d     = count_q;
    remain_d    = remain_q;
    count_inc   = count_q;
    done_d      = 1'b0;
    buf_valid_c = 1'b0;
    buf_next_c  = 1'b0;

    case (state_q)
      KBC_IDLE: ;
      KBC_FLUSH: begin
        buf_next_c = 1'b1;
        if (flush_q == FL_W'(SIZE - 1)) state_d = KBC_FILL;
        else                            flush_d = flush_q + 1'b1;
      end
      KBC_FILL: begin
        buf_valid_c = bus.i_kp_valid;
        if (bus.i_kp_valid && (count_q != CNT_W'(SIZE))) count_inc = count_q + 1'b1;
        count_d = count_inc;
        if (bus.i_frame_end) begin
          if (count_inc == '0) begin
            state_d = KBC_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = KBC_DRAIN;
            remain_d = count_inc;
          end
        end
      end
      KBC_DRAIN: begin
        if ((remain_q != '0) && bus.i_drain_ready) begin
          buf_next_c = 1'b1;
          remain_d   = remain_q - 1'b1;
          if (remain_q == CNT_W'(1)) begin
            state_d = KBC_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = KBC_IDLE;
    endcase

    // A new frame start overrides everything, including an in-progress drain
    if (bus.i_frame_start) begin
      state_d  = KBC_FLUSH;
      flush_d  = '0;
      count_d  = '0;
      remain_d = '0;
      done_d   = 1'b0;
    end

    busy_d   = (state_d != KBC_IDLE);
    dvalid_d = (state_d == KBC_DRAIN) && (remain_d != '0);
    dlast_d  = (state_d == KBC_DRAIN) && (remain_d == CNT_W'(1));
  end

  // State and registered-output flops
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= KBC_IDLE;
      flush_q  <= '0;
      count_q  <= '0;
      remain_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      dvalid_q <= 1'b0;
      dlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      count_q  <= count_d;
      remain_q <= remain_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      dvalid_q <= dvalid_d;
      dlast_q  <= dlast_d;
    end
  end

  assign bus.o_buf_valid   = buf_valid_c;
  assign bus.o_buf_next    = buf_next_c;
  assign bus.o_drain_valid = dvalid_q;
  assign bus.o_drain_last  = dlast_q;
  assign bus.o_frame_done  = done_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_kp_count    = KBC_CNT_W'(count_q);

`ifdef KEY_BUFFER_CTRL_DROP_CNT_EN
  logic [KBC_DROP_W-1:0] drop_q, drop_d;

  // Candidates seen outside FILL or beyond buffer capacity, saturating
  always_comb begin
    drop_d = drop_q;
    if (bus.i_frame_start) begin
      drop_d = '0;
    end else if (bus.i_kp_valid && ((state_q != KBC_FILL) || (count_q == CNT_W'(SIZE)))
                 && (drop_q != {KBC_DROP_W{1'b1}})) begin
      drop_d = drop_q + 1'b1;
    end
  end

  // Drop counter register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) drop_q <= '0;
    else          drop_q <= drop_d;
  end

  assign bus.o_drop_count = drop_q;
`endif

endmodule

// File: tb/tb_key_buffer_ctrl.sv
// Directed self-checking bench for key_buffer_ctrl (SIZE = 10).
module tb_key_buffer_ctrl;

  localparam int unsigned SIZE = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  key_buffer_ctrl_if bus();

  key_buffer_ctrl #(.SIZE(SIZE)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  // {busy, buf_valid, buf_next, drain_valid, drain_last, frame_done}
  function automatic logic [5:0] outs();
    return {bus.o_busy, bus.o_buf_valid, bus.o_buf_next,
            bus.o_drain_valid, bus.o_drain_last, bus.o_frame_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic e, input logic kv, input logic rdy);
    bus.i_frame_start = s;
    bus.i_frame_end   = e;
    bus.i_kp_valid    = kv;
    bus.i_drain_ready = rdy;
  endtask

  task automatic start_to_fill();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (SIZE) tick();
  endtask

  // n candidates, frame_end on the last one
  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, (i == n - 1), 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if (outs() !== 6'b000000) begin
      n_err++; $display("FAIL reset_outs got %b exp %b", outs(), 6'b000000);
    end
    n_cmp++;
    if (bus.o_kp_count !== 10'd0) begin
      n_err++; $display("FAIL reset_count got %0d exp 0", bus.o_kp_count);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ignore();
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (outs() !== 6'b000000) begin
      n_err++; $display("FAIL idle_ignore got %b exp %b", outs(), 6'b000000);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (outs() !== 6'b000000 || bus.o_kp_count !== 10'd0) begin
      n_err++; $display("FAIL idle_stays got %b/%0d exp %b/0", outs(), bus.o_kp_count, 6'b000000);
    end
    tick();
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (outs() !== 6'b000000) begin
      n_err++; $display("FAIL flush_start_cycle got %b exp %b", outs(), 6'b000000);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < SIZE; i++) begin
      @(negedge clk);
      n_cmp++;
      if (outs() !== 6'b101000) begin
        n_err++; $display("FAIL flush_cyc%0d got %b exp %b", i, outs(), 6'b101000);
      end
      tick();
    end
    @(negedge clk);
    n_cmp++;
    if (outs() !== 6'b100000 || bus.o_kp_count !== 10'd0) begin
      n_err++; $display("FAIL flush_to_fill got %b/%0d exp %b/0", outs(), bus.o_kp_count, 6'b100000);
    end
    tick();
  endtask

  task automatic test_four();
    start_to_fill();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, (i == 3), 1'b1, 1'b1);
      @(negedge clk);
      n_cmp++;
      if (outs() !== 6'b110000) begin
        n_err++; $display("FAIL four_fill%0d got %b exp %b", i, outs(), 6'b110000);
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      logic [5:0] exp_o;
      exp_o = (k == 3) ? 6'b101110 : 6'b101100;
      @(negedge clk);
      n_cmp++;
      if (outs() !== exp_o || bus.o_kp_count !== 10'd4) begin
        n_err++; $display("FAIL four_beat%0d got %b/%0d exp %b/4", k, outs(), bus.o_kp_count, exp_o);
      end
      tick();
    end
    @(negedge clk);
    n_cmp++;
    if (outs() !== 6'b000001) begin
      n_err++; $display("FAIL four_done got %b exp %b", outs(), 6'b000001);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (outs() !== 6'b000000) begin
      n_err++; $display("FAIL four_done_pulse got %b exp %b", outs(), 6'b000000);
    end
    tick();
  endtask

  task automatic test_saturate();
    int beats;
    int n_last;
    int last_at;
    logic done;
    beats = 0; n_last = 0; last_at = 0; done = 1'b0;
    start_to_fill();
    feed(15);
    @(negedge clk);
    n_cmp++;
    if (outs() !== 6'b100100 || bus.o_kp_count !== 10'd10) begin
      n_err++; $display("FAIL sat_count got %b/%0d exp %b/10", outs(), bus.o_kp_count, 6'b100100);
    end
`ifdef KEY_BUFFER_CTRL_DROP_CNT_EN
    n_cmp++;
    if (bus.o_drop_count !== 16'd5) begin
      n_err++; $display("FAIL sat_drop got %0d exp 5", bus.o_drop_count);
    end
`endif
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int cyc = 0; cyc < 30 && !done; cyc++) begin
      @(negedge clk);
      if (bus.o_frame_done) done = 1'b1;
      else if (bus.o_drain_valid && bus.o_buf_next) begin
        beats++;
        if (bus.o_drain_last) begin n_last++; last_at = beats; end
      end
      tick();
    end
    n_cmp++;
    if (!done) begin
      n_err++; $display("FAIL sat_done_timeout got 0 exp 1");
    end
    n_cmp++;
    if (beats != 10 || n_last != 1 || last_at != 10) begin
      n_err++; $display("FAIL sat_beats got %0d/%0d/%0d exp 10/1/10", beats, n_last, last_at);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    logic [5:0] exp_tab [5];
    logic       rdy_tab [5];
    exp_tab = '{6'b101100, 6'b100100, 6'b101100, 6'b100110, 6'b101110};
    rdy_tab = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    start_to_fill();
    feed(3);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, rdy_tab[i]);
      @(negedge clk);
      n_cmp++;
      if (outs() !== exp_tab[i] || bus.o_kp_count !== 10'd3) begin
        n_err++; $display("FAIL stall_cyc%0d got %b/%0d exp %b/3", i, outs(), bus.o_kp_count, exp_tab[i]);
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (outs() !== 6'b000001) begin
      n_err++; $display("FAIL stall_done got %b exp %b", outs(), 6'b000001);
    end
    tick();
  endtask

  task automatic test_abort();
    logic done_seen;
    done_seen = 1'b0;
    start_to_fill();
    feed(5);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (outs() !== 6'b101100) begin
        n_err++; $display("FAIL abort_beat%0d got %b exp %b", i, outs(), 6'b101100);
      end
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (outs() !== 6'b100100) begin
      n_err++; $display("FAIL abort_start_cycle got %b exp %b", outs(), 6'b100100);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (outs() !== 6'b101000 || bus.o_kp_count !== 10'd0) begin
      n_err++; $display("FAIL abort_to_flush got %b/%0d exp %b/0", outs(), bus.o_kp_count, 6'b101000);
    end
    for (int i = 0; i < SIZE; i++) begin
      @(negedge clk);
      if (bus.o_frame_done) done_seen = 1'b1;
      tick();
    end
    n_cmp++;
    if (done_seen) begin
      n_err++; $display("FAIL abort_no_done got 1 exp 0");
    end
  endtask

  task automatic test_start_wins();
    start_to_fill();
    feed(0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (outs() !== 6'b110000) begin
      n_err++; $display("FAIL startwin_cycle got %b exp %b", outs(), 6'b110000);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (outs() !== 6'b101000 || bus.o_kp_count !== 10'd0) begin
      n_err++; $display("FAIL startwin_flush got %b/%0d exp %b/0", outs(), bus.o_kp_count, 6'b101000);
    end
    tick();
  endtask

  task automatic test_reset_mid_flush();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (outs() !== 6'b101000) begin
      n_err++; $display("FAIL rstflush_before got %b exp %b", outs(), 6'b101000);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (outs() !== 6'b000000 || bus.o_kp_count !== 10'd0) begin
      n_err++; $display("FAIL rstflush_after got %b/%0d exp %b/0", outs(), bus.o_kp_count, 6'b000000);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_frame();
    start_to_fill();
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (outs() !== 6'b100000) begin
      n_err++; $display("FAIL zero_end_cycle got %b exp %b", outs(), 6'b100000);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (outs() !== 6'b000001) begin
      n_err++; $display("FAIL zero_done got %b exp %b", outs(), 6'b000001);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (outs() !== 6'b000000) begin
      n_err++; $display("FAIL zero_idle got %b exp %b", outs(), 6'b000000);
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    test_reset();
    test_ignore();
    test_flush();
    test_four();
    test_saturate();
    test_stall();
    test_abort();
    test_start_wins();
    test_reset_mid_flush();
    test_zero_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
